// File: rtl/ext_bus_pkg.sv
// Shared types and constants for the external bus arbiter.
package ext_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam logic [31:0] NOP_INS_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, registered last-grant flag.
module rr_arb2
  import ext_bus_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic req_d,
  input  logic upd,
  input  logic upd_id,
  output logic gnt_valid_c,
  output logic gnt_id_c
);

  logic last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= GNT_D;
    end else if (upd) begin
      last_q <= upd_id;
    end
  end

  // On a tie the side not served last wins
  always_comb begin
    gnt_valid_c = req_i | req_d;
    gnt_id_c    = GNT_I;
    if (req_i && req_d) begin
      gnt_id_c = (last_q == GNT_D) ? GNT_I : GNT_D;
    end else if (req_d) begin
      gnt_id_c = GNT_D;
    end
  end

endmodule

// File: rtl/ext_bus_arb.sv
// Arbitrates the external memory bus between fetch and load/store, one transaction at a time.
// Optional bus-ack timeout enabled by defining EXT_BUS_TIMEOUT_EN.
module ext_bus_arb
  import ext_bus_pkg::*;
#(
  parameter int unsigned   AW      = 32,
  parameter int unsigned   DW      = 32,
  parameter logic [DW-1:0] NOP_INS = DW'(NOP_INS_DEFAULT)
`ifdef EXT_BUS_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_wstrb,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic [3:0]    bus_wstrb,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic          bus_err
);

  state_t          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            gnt_valid_c, gnt_id_c, upd_c;
  logic            abort_c;
  logic            bus_req_d, bus_we_d;
  logic [AW-1:0]   bus_addr_d;
  logic [DW-1:0]   bus_wdata_d;
  logic [3:0]      bus_wstrb_d;
  logic            if_valid_d, d_ready_d;
  logic [DW-1:0]   if_rdata_d, d_rdata_d;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (if_req),
    .req_d       (d_req),
    .upd         (upd_c),
    .upd_id      (gnt_q),
    .gnt_valid_c (gnt_valid_c),
    .gnt_id_c    (gnt_id_c)
  );

`ifdef EXT_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_q;
  logic             err_q;

  // Counts bus cycles without ack; abort when the count would reach TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (state_q == IDLE) begin
      tmo_q <= '0;
    end else if ((state_q == BUS_I || state_q == BUS_D) && !bus_ack) begin
      tmo_q <= tmo_q + CNT_W'(1);
    end
  end

  assign abort_c = !bus_ack && ((tmo_q + CNT_W'(1)) == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_q == BUS_I || state_q == BUS_D) && abort_c;
    end
  end

  assign bus_err = err_q;
`else
  assign abort_c = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    upd_c       = 1'b0;
    bus_req_d   = bus_req;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    bus_wstrb_d = bus_wstrb;
    if_valid_d  = 1'b0;
    d_ready_d   = 1'b0;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid_c) begin
          gnt_d     = gnt_id_c;
          bus_req_d = 1'b1;
          if (gnt_id_c == GNT_I) begin
            state_d     = BUS_I;
            bus_we_d    = 1'b0;
            bus_addr_d  = if_addr;
            bus_wdata_d = '0;
            bus_wstrb_d = '0;
          end else begin
            state_d     = BUS_D;
            bus_we_d    = d_we;
            bus_addr_d  = d_addr;
            bus_wdata_d = d_wdata;
            bus_wstrb_d = d_wstrb;
          end
        end
      end
      BUS_I, BUS_D: begin
        // Ack takes priority over a simultaneous timeout
        if (bus_ack || abort_c) begin
          bus_req_d = 1'b0;
          state_d   = RESP;
          if (state_q == BUS_I) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus_ack ? bus_rdata : NOP_INS;
          end else begin
            d_ready_d = 1'b1;
            if (!bus_we) begin
              d_rdata_d = bus_ack ? bus_rdata : '0;
            end
          end
        end
      end
      RESP: begin
        upd_c   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_D;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      if_valid  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= NOP_INS;
      d_rdata   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      bus_req   <= bus_req_d;
      bus_we    <= bus_we_d;
      bus_addr  <= bus_addr_d;
      bus_wdata <= bus_wdata_d;
      bus_wstrb <= bus_wstrb_d;
      if_valid  <= if_valid_d;
      d_ready   <= d_ready_d;
      if_rdata  <= if_rdata_d;
      d_rdata   <= d_rdata_d;
    end
  end

endmodule
